ps2_host_tx: RTL and testbench

Host-to-device transmitter for the PS/2 port. It is the send-side counterpart of the existing PS/2 keyboard receiver, and it lets the game send command bytes to the keyboard, e.g. 0xED set-LEDs or 0xFF reset. It drives the open-drain ps2_clk/ps2_data lines through active-low enables and runs the inhibit/request-to-send sequence. It shifts out an 11-bit frame on device-generated clocks and reports the line ACK. Its busy output gates the receiver so the receiver does not decode the outgoing frame.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 43 ++++
 rtl/ps2_host_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 shared definitions for the host transmitter and the keyboard receiver.
//   ps2_state_e            : transmitter state encoding
//   FRAME_BITS             : data(8) + parity + stop bits shifted after the start bit
//   DEFAULT_INHIBIT_CYCLES : ps2_clk hold-low time before request-to-send
//   DEFAULT_TIMEOUT_CYCLES : maximum gap between device clock falling edges
//   odd_parity()           : PS/2 odd-parity bit for a data byte
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SEND,
      ACK,
      WAIT_IDLE,
      DONE
   } ps2_state_e;

   localparam int FRAME_BITS             = 10;
   localparam int DEFAULT_INHIBIT_CYCLES = 12000;
   localparam int DEFAULT_TIMEOUT_CYCLES = 2000000;

   // Parity bit that makes the total count of ones over data+parity odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw ps2_clk / ps2_data pad levels into the clk domain and
// flags falling edges of the synchronized ps2_clk.
//   clk, rst     : system clock, synchronous active-high reset
//   ps2_clk_in   : raw ps2_clk pad level (asynchronous)
//   ps2_data_in  : raw ps2_data pad level (asynchronous)
//   clk_s        : synchronized ps2_clk
//   data_s       : synchronized ps2_data
//   clk_fall     : one-cycle flag, synchronized ps2_clk went 1 -> 0
// SYNC_STAGES must be at least 2.
module ps2_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);

   logic [SYNC_STAGES-1:0] clk_sr;
   logic [SYNC_STAGES-1:0] data_sr;
   logic                   clk_prev;

   // Reset to the idle (pulled-up) level so leaving reset never looks like an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sr   <= '1;
         data_sr  <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk_in};
         data_sr  <= {data_sr[SYNC_STAGES-2:0], ps2_data_in};
         clk_prev <= clk_sr[SYNC_STAGES-1];
      end
   end

   assign clk_s    = clk_sr[SYNC_STAGES-1];
   assign data_s   = data_sr[SYNC_STAGES-1];
   assign clk_fall = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Runs inhibit / request-to-send, shifts an
// 11-bit frame out on device-generated clocks, and reports the line ACK.
//   clk, rst           : 100 MHz system clock, synchronous active-high reset
//   tx_data, tx_valid  : command byte and request; accepted when tx_ready
//   tx_ready           : high only in IDLE
//   ps2_clk_in         : raw ps2_clk pad level
//   ps2_data_in        : raw ps2_data pad level
//   ps2_clk_drive_low  : 1 pulls ps2_clk low, 0 releases it
//   ps2_data_drive_low : 1 pulls ps2_data low, 0 releases it
//   busy               : transfer in progress (gates the receiver)
//   done               : one-cycle end-of-transfer pulse
//   ack_ok / err_noack / err_timeout : exactly one pulses with done
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drive_low,
   output logic       ps2_data_drive_low,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       err_noack,
   output logic       err_timeout
);

   // One counter serves both the inhibit hold and the edge-gap watchdog.
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 1);

   logic clk_s, data_s, clk_fall;

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .clk_s       (clk_s),
      .data_s      (data_s),
      .clk_fall    (clk_fall)
   );

   ps2_state_e                state_q, state_n;
   logic [CNT_W-1:0]          cnt_q, cnt_n;
   logic [3:0]                bit_idx_q, bit_idx_n;
   logic [FRAME_BITS-1:0]     frame_q, frame_n;
   logic                      ack_bit_q, ack_bit_n;
   logic                      clk_dl_n, data_dl_n;
   logic                      done_n, ack_ok_n, noack_n, tmo_n;
   logic                      watching, bus_idle;

   assign watching = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
   assign bus_idle = clk_s & data_s;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      bit_idx_n = bit_idx_q;
      frame_n   = frame_q;
      ack_bit_n = ack_bit_q;
      clk_dl_n  = ps2_clk_drive_low;
      data_dl_n = ps2_data_drive_low;
      done_n    = 1'b0;
      ack_ok_n  = 1'b0;
      noack_n   = 1'b0;
      tmo_n     = 1'b0;

      case (state_q)
         IDLE: begin
            clk_dl_n  = 1'b0;
            data_dl_n = 1'b0;
            if (tx_valid) begin
               frame_n  = {1'b1, odd_parity(tx_data), tx_data};
               cnt_n    = '0;
               clk_dl_n = 1'b1;
               state_n  = INHIBIT;
            end
         end
         INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               data_dl_n = 1'b1;            // start bit
               cnt_n     = '0;
               state_n   = REQ;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         REQ: begin
            clk_dl_n  = 1'b0;
            bit_idx_n = '0;
            cnt_n     = '0;
            state_n   = SEND;
         end
         SEND: begin
            if (clk_fall) begin
               data_dl_n = ~frame_q[bit_idx_q];
               bit_idx_n = bit_idx_q + 1'b1;
               cnt_n     = '0;
               if (bit_idx_q == IDX_LAST) state_n = ACK;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         ACK: begin
            data_dl_n = 1'b0;
            if (clk_fall) begin
               ack_bit_n = ~data_s;
               cnt_n     = '0;
               state_n   = WAIT_IDLE;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (bus_idle) begin
               done_n   = 1'b1;
               ack_ok_n = ack_bit_q;
               noack_n  = ~ack_bit_q;
               state_n  = DONE;
            end else if (clk_fall) begin
               cnt_n = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         DONE: begin
            clk_dl_n  = 1'b0;
            data_dl_n = 1'b0;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // Edge-gap watchdog; a fall in the same cycle (or a completed WAIT_IDLE) wins.
      if (watching && !clk_fall && (cnt_q == TMO_LAST) &&
          !((state_q == WAIT_IDLE) && bus_idle)) begin
         clk_dl_n  = 1'b0;
         data_dl_n = 1'b0;
         done_n    = 1'b1;
         tmo_n     = 1'b1;
         cnt_n     = '0;
         state_n   = IDLE;
      end
   end

   // NOTE: state and registered outputs use non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= IDLE;
         cnt_q              <= '0;
         bit_idx_q          <= '0;
         frame_q            <= '0;
         ack_bit_q          <= 1'b0;
         ps2_clk_drive_low  <= 1'b0;
         ps2_data_drive_low <= 1'b0;
         done               <= 1'b0;
         ack_ok             <= 1'b0;
         err_noack          <= 1'b0;
         err_timeout        <= 1'b0;
      end else begin
         state_q            <= state_n;
         cnt_q              <= cnt_n;
         bit_idx_q          <= bit_idx_n;
         frame_q            <= frame_n;
         ack_bit_q          <= ack_bit_n;
         ps2_clk_drive_low  <= clk_dl_n;
         ps2_data_drive_low <= data_dl_n;
         done               <= done_n;
         ack_ok             <= ack_ok_n;
         err_noack          <= noack_n;
         err_timeout        <= tmo_n;
      end
   end

   assign tx_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain bus plus a behavioural
// PS/2 device that clocks at a 40-cycle period, samples bits on rising edges
// and optionally acknowledges, stalls or stays silent.
module tb_ps2_host_tx;

   localparam int INH = 20;
   localparam int TMO = 400;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clk_drive_low, ps2_data_drive_low;
   logic       busy, done, ack_ok, err_noack, err_timeout;

   logic dev_clk  = 1'b1;
   logic dev_data = 1'b1;
   logic ps2_clk_line, ps2_data_line;

   // Wired-AND open-drain lines with pull-ups.
   assign ps2_clk_line  = ~ps2_clk_drive_low  & dev_clk;
   assign ps2_data_line = ~ps2_data_drive_low & dev_data;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .tx_data            (tx_data),
      .tx_valid           (tx_valid),
      .tx_ready           (tx_ready),
      .ps2_clk_in         (ps2_clk_line),
      .ps2_data_in        (ps2_data_line),
      .ps2_clk_drive_low  (ps2_clk_drive_low),
      .ps2_data_drive_low (ps2_data_drive_low),
      .busy               (busy),
      .done               (done),
      .ack_ok             (ack_ok),
      .err_noack          (err_noack),
      .err_timeout        (err_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Completion monitor.
   int   done_cnt = 0;
   int   stray_cnt = 0;
   int   done_cyc = 0;
   logic last_ack = 1'b0, last_noack = 1'b0, last_tmo = 1'b0;
   logic last_clk_dl = 1'b0, last_data_dl = 1'b0;
   logic prev_done = 1'b0;
   logic busy_after_done = 1'b1;

   always @(negedge clk) begin
      if (done) begin
         done_cnt     <= done_cnt + 1;
         done_cyc     <= cyc;
         last_ack     <= ack_ok;
         last_noack   <= err_noack;
         last_tmo     <= err_timeout;
         last_clk_dl  <= ps2_clk_drive_low;
         last_data_dl <= ps2_data_drive_low;
      end
      if (!done && (ack_ok || err_noack || err_timeout)) stray_cnt <= stray_cnt + 1;
      if (prev_done) busy_after_done <= busy;
      prev_done <= done;
   end

   // Reference frame: data LSB first, odd parity, stop bit.
   function automatic logic [9:0] model_frame(input logic [7:0] d);
      logic [9:0] f;
      for (int i = 0; i < 8; i++) f[i] = d[i];
      f[8] = (($countones(d) % 2) == 0);
      f[9] = 1'b1;
      return f;
   endfunction

   // Host request plus device behaviour; returns what the device observed.
   task automatic drive_frame(input logic [7:0] d, input int n_falls, input bit ack_low,
                              input int stall_after, input int stall_len,
                              output int inh_len, output int req_len, output bit start_low,
                              output logic [9:0] sampled, output int rel_cyc);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      inh_len = 0;
      while (ps2_clk_drive_low && !ps2_data_drive_low && inh_len < 5000) begin
         inh_len++;
         @(negedge clk);
      end
      req_len = 0;
      while (ps2_clk_drive_low && ps2_data_drive_low && req_len < 5000) begin
         req_len++;
         @(negedge clk);
      end
      rel_cyc   = cyc;
      start_low = ps2_data_drive_low && !ps2_clk_drive_low;
      sampled   = '0;
      repeat (30) @(negedge clk);
      for (int k = 1; k <= n_falls; k++) begin
         dev_clk = 1'b0;
         repeat (20) @(negedge clk);
         dev_clk = 1'b1;
         if (k <= 10) sampled[k-1] = ps2_data_line;
         if (k == 11) dev_data = 1'b1;
         if (k == 10 && ack_low) begin
            repeat (10) @(negedge clk);
            dev_data = 1'b0;
            repeat (10) @(negedge clk);
         end else begin
            repeat (20) @(negedge clk);
         end
         if (k == stall_after) repeat (stall_len) @(negedge clk);
      end
   endtask

   task automatic wait_done(input int start, input int bound, output bit got);
      int n = 0;
      while (done_cnt == start && n < bound) begin
         @(negedge clk);
         n++;
      end
      got = (done_cnt != start);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
      checks++; if (ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0)
         $display("FAIL reset_lines got=%b%b exp=00", ps2_clk_drive_low, ps2_data_drive_low); else passes++;
      checks++; if ({done, ack_ok, err_noack, err_timeout} !== 4'b0000)
         $display("FAIL reset_pulses got=%b exp=0000", {done, ack_ok, err_noack, err_timeout}); else passes++;
   endtask

   // Full frame with a device response; compares frame and outcome to the model.
   task automatic test_frame(input string name, input logic [7:0] d, input bit ack_low);
      int inh, req, rel, start;
      bit sl, got;
      logic [9:0] smp, exp_f;
      start = done_cnt;
      exp_f = model_frame(d);
      drive_frame(d, 11, ack_low, 0, 0, inh, req, sl, smp, rel);
      wait_done(start, 500, got);
      checks++; if (inh != INH) $display("FAIL %s inhibit_len got=%0d exp=%0d", name, inh, INH); else passes++;
      checks++; if (req != 1) $display("FAIL %s req_len got=%0d exp=1", name, req); else passes++;
      checks++; if (sl !== 1'b1) $display("FAIL %s start_bit_low got=%b exp=1", name, sl); else passes++;
      checks++; if (smp !== exp_f) $display("FAIL %s frame got=%b exp=%b", name, smp, exp_f); else passes++;
      checks++; if (!got) $display("FAIL %s done_seen got=0 exp=1", name); else passes++;
      checks++; if ({last_ack, last_noack, last_tmo} !== {ack_low, !ack_low, 1'b0})
         $display("FAIL %s outcome got=%b exp=%b", name, {last_ack, last_noack, last_tmo},
                  {ack_low, !ack_low, 1'b0}); else passes++;
      checks++; if ({last_clk_dl, last_data_dl} !== 2'b00)
         $display("FAIL %s lines_at_done got=%b exp=00", name, {last_clk_dl, last_data_dl}); else passes++;
      checks++; if (busy_after_done !== 1'b0)
         $display("FAIL %s busy_after_done got=%b exp=0", name, busy_after_done); else passes++;
   endtask

   task automatic test_ed();
      test_frame("ed_ack", 8'hED, 1'b1);
   endtask

   task automatic test_parity();
      test_frame("parity_00", 8'h00, 1'b1);
      test_frame("parity_01", 8'h01, 1'b1);
   endtask

   task automatic test_noack();
      test_frame("noack", 8'($urandom), 1'b0);
   endtask

   task automatic test_timeout_silent();
      int inh, req, rel, start;
      bit sl, got;
      logic [9:0] smp;
      start = done_cnt;
      drive_frame(8'($urandom), 0, 1'b0, 0, 0, inh, req, sl, smp, rel);
      wait_done(start, 1000, got);
      checks++; if (!got) $display("FAIL silent done_seen got=0 exp=1"); else passes++;
      checks++; if ({last_ack, last_noack, last_tmo} !== 3'b001)
         $display("FAIL silent outcome got=%b exp=001", {last_ack, last_noack, last_tmo}); else passes++;
      checks++; if (done_cyc - rel != TMO)
         $display("FAIL silent timeout_latency got=%0d exp=%0d", done_cyc - rel, TMO); else passes++;
      checks++; if ({last_clk_dl, last_data_dl} !== 2'b00)
         $display("FAIL silent lines_at_done got=%b exp=00", {last_clk_dl, last_data_dl}); else passes++;
   endtask

   task automatic test_stall();
      int inh, req, rel, start;
      bit sl, got;
      logic [9:0] smp;
      start = done_cnt;
      drive_frame(8'h5C, 4, 1'b1, 4, 500, inh, req, sl, smp, rel);
      wait_done(start, 100, got);
      checks++; if (!got) $display("FAIL stall done_seen got=0 exp=1"); else passes++;
      checks++; if ({last_ack, last_noack, last_tmo} !== 3'b001)
         $display("FAIL stall outcome got=%b exp=001", {last_ack, last_noack, last_tmo}); else passes++;
      checks++; if (done_cnt != start + 1)
         $display("FAIL stall done_count got=%0d exp=%0d", done_cnt - start, 1); else passes++;
      test_frame("after_stall_ff", 8'hFF, 1'b1);
   endtask

   task automatic test_reset_mid();
      int inh, req, rel, start;
      bit sl;
      logic [9:0] smp;
      start = done_cnt;
      drive_frame(8'h2A, 5, 1'b1, 0, 0, inh, req, sl, smp, rel);
      checks++; if (busy !== 1'b1 || ps2_data_drive_low !== 1'b1)
         $display("FAIL rst_mid pre_state got=%b%b exp=11", busy, ps2_data_drive_low); else passes++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({ps2_clk_drive_low, ps2_data_drive_low, busy} !== 3'b000)
         $display("FAIL rst_mid released got=%b exp=000", {ps2_clk_drive_low, ps2_data_drive_low, busy}); else passes++;
      repeat (50) @(negedge clk);
      checks++; if (done_cnt != start)
         $display("FAIL rst_mid no_done got=%0d exp=0", done_cnt - start); else passes++;
      test_frame("after_rst_f4", 8'hF4, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         test_frame("random", 8'($urandom), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ed();
      test_parity();
      test_noack();
      test_timeout_silent();
      test_stall();
      test_reset_mid();
      test_random();
      repeat (5) @(negedge clk);
      checks++; if (stray_cnt != 0)
         $display("FAIL stray_result_pulses got=%0d exp=0", stray_cnt); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
